// File: rtl/adder_mon_pkg.sv
// Shared types and helpers for the approximate-adder error monitors.
package adder_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  // Error-distance accumulator width: one window of worst-case distances cannot overflow it.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned win_log2);
    return width + 1 + win_log2;
  endfunction

endpackage

// File: rtl/adder_ed_calc.sv
// Combinational error distance |(add1 + add2 + CIN) - approx| for a WIDTH-bit adder under test.
module adder_ed_calc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CIN   = 1
) (
  input  logic [WIDTH-1:0] add1,
  input  logic [WIDTH-1:0] add2,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   ed
);

  localparam int unsigned RW = WIDTH + 1;

  logic [RW-1:0] w_exact;

  // The exact sum fits in WIDTH+1 bits even with the carry-in.
  always_comb begin
    w_exact = RW'(add1) + RW'(add2) + RW'(CIN);
    ed      = (w_exact >= approx) ? (w_exact - approx) : (approx - w_exact);
  end

endmodule

// File: rtl/adder_error_monitor.sv
// Windowed error statistics (count, summed and maximum error distance) for an approximate adder.
module adder_error_monitor
  import adder_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CIN      = 1,
  parameter int unsigned WIN_LOG2 = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         sample_valid_i,
  input  logic [WIDTH-1:0]             add1_i,
  input  logic [WIDTH-1:0]             add2_i,
  input  logic [WIDTH:0]               approx_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [WIN_LOG2:0]            err_count_o,
  output logic [WIDTH+WIN_LOG2:0]      sum_ed_o,
  output logic [WIDTH:0]               max_ed_o
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = WIN_LOG2;
  localparam int unsigned EW = WIN_LOG2 + 1;
  localparam int unsigned AW = acc_width(WIDTH, WIN_LOG2);

  mon_state_e      r_state;
  mon_state_e      w_next;
  logic            w_take_start;
  logic            w_accept;
  logic            w_last;

  logic [CW-1:0]   r_cnt;
  logic            r_s1_valid;
  logic [WIDTH-1:0] r_s1_add1;
  logic [WIDTH-1:0] r_s1_add2;
  logic [RW-1:0]   r_s1_approx;
  logic [RW-1:0]   w_ed;

  logic            r_busy;
  logic            r_done;
  logic [EW-1:0]   r_err_count;
  logic [AW-1:0]   r_sum_ed;
  logic [RW-1:0]   r_max_ed;

  assign w_last = (r_cnt == {CW{1'b1}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state plus the start/accept strobes that steer the datapath.
  always_comb begin
    w_next       = r_state;
    w_take_start = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next       = RUN;
          w_take_start = 1'b1;
        end
      end
      RUN: begin
        if (sample_valid_i) begin
          w_accept = 1'b1;
          if (w_last) w_next = DRAIN;
        end
      end
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status flags track the upcoming state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_add1   <= '0;
      r_s1_add2   <= '0;
      r_s1_approx <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_take_start) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt       <= r_cnt + CW'(1);
        r_s1_add1   <= add1_i;
        r_s1_add2   <= add2_i;
        r_s1_approx <= approx_i;
      end
    end
  end

  adder_ed_calc #(
    .WIDTH (WIDTH),
    .CIN   (CIN)
  ) u_ed_calc (
    .add1   (r_s1_add1),
    .add2   (r_s1_add2),
    .approx (r_s1_approx),
    .ed     (w_ed)
  );

  // Stage 2: fold the registered sample into the window statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_count <= '0;
      r_sum_ed    <= '0;
      r_max_ed    <= '0;
    end else if (w_take_start) begin
      r_err_count <= '0;
      r_sum_ed    <= '0;
      r_max_ed    <= '0;
    end else if (r_s1_valid) begin
      r_err_count <= r_err_count + EW'(w_ed != '0);
      r_sum_ed    <= r_sum_ed + AW'(w_ed);
      if (w_ed > r_max_ed) r_max_ed <= w_ed;
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_count_o = r_err_count;
  assign sum_ed_o    = r_sum_ed;
  assign max_ed_o    = r_max_ed;

endmodule
